// File: rtl/fetch_queue_pkg.sv
// Fetch queue entry layout.
// Each entry holds a word-address PC and the instruction fetched from that address.
package fetch_queue_pkg;
    localparam int FQ_ENTRY_W = 62;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
    } fq_entry_t;
endpackage

// File: rtl/mips_pkg.sv
// Constants shared by the PC register and the fetch queue.
// These are the reset fetch address (byte address 0x3000) and the NOP encoding.
package mips_pkg;
    localparam logic [29:0] RESET_PC  = 30'h0000_0C00;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;
endpackage

// File: rtl/fetch_queue_mem.sv
// fq_mem: DEPTH x W storage with one synchronous write port and one async read port.
// Latency: the write is visible on the read port the cycle after wr_en. No backpressure.
// The array has no reset; the queue's count decides which entries are meaningful.
module fq_mem #(
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int W     = 62
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [W-1:0]  wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: FIFO of {pc, instr} between fetch and decode; optional macro FETCH_QUEUE_BYPASS_EN.
// Latency: an entry pushed into an empty queue reaches the head one cycle later (same cycle with bypass).
// Backpressure: full stalls the PC register; a push into a full queue is dropped unless pop frees a slot.
module fetch_queue
    import mips_pkg::*;
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     CLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic [29:0]              pc_in,
    input  logic [31:0]              instr_in,
    input  logic                     pop,
    input  logic                     flush,
    output logic [29:0]              pc_out,
    output logic [31:0]              instr_out,
    output logic                     valid_out,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic      empty;
    logic      is_full;
    logic      pop_ok;
    logic      push_ok;
    logic      bypass;
    logic      wr_en;
    fq_entry_t wr_entry;
    fq_entry_t rd_entry;

    assign empty   = (cnt == '0);
    assign is_full = (cnt == DEPTH_C);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!is_full || pop_ok);

`ifdef FETCH_QUEUE_BYPASS_EN
    // Empty queue forwards the fetch straight to decode; only kept if decode does not take it.
    assign bypass = empty && push && !flush;
`else
    assign bypass = 1'b0;
`endif

    assign wr_en = push_ok && !(bypass && pop);

    assign wr_entry.pc    = pc_in;
    assign wr_entry.instr = instr_in;

    always_ff @(posedge CLK) begin
        if (reset || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            cnt <= cnt + CW'(wr_en) - CW'(pop_ok);
        end
    end

    fq_mem #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .W     (FQ_ENTRY_W)
    ) u_mem (
        .clk     (CLK),
        .wr_en   (wr_en && !reset && !flush),
        .wr_addr (wr_ptr),
        .wr_data (wr_entry),
        .rd_addr (rd_ptr),
        .rd_data (rd_entry)
    );

    always_comb begin
        valid_out = !empty;
        pc_out    = RESET_PC;
        instr_out = NOP_INSTR;
        if (bypass) begin
            valid_out = 1'b1;
            pc_out    = pc_in;
            instr_out = instr_in;
        end else if (!empty) begin
            pc_out    = rd_entry.pc;
            instr_out = rd_entry.instr;
        end
    end

    assign full  = is_full;
    assign count = cnt;
endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: vector table with constant expectations plus a scoreboard FIFO.
module tb_fetch_queue;
    localparam int DEPTH = 4;

    logic        CLK = 1'b0;
    logic        reset, push, pop, flush;
    logic [29:0] pc_in;
    logic [31:0] instr_in;
    logic [29:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out, full;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [29:0] pc;
        logic [31:0] instr;
    } ent_t;

    typedef struct {
        logic        rst, p, o, f;
        logic [29:0] pc;
        logic [2:0]  cnt;
        logic        v, fl;
        logic [29:0] hpc;
    } vec_t;

    ent_t model[$];
    vec_t vecs[19];

    always #5 CLK = ~CLK;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .CLK       (CLK),
        .reset     (reset),
        .push      (push),
        .pc_in     (pc_in),
        .instr_in  (instr_in),
        .pop       (pop),
        .flush     (flush),
        .pc_out    (pc_out),
        .instr_out (instr_out),
        .valid_out (valid_out),
        .full      (full),
        .count     (count)
    );

    function automatic logic [31:0] mk(input logic [29:0] pc);
        return 32'h3C01_0001 + {2'b00, pc} - 32'h0000_0C00;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the scoreboard is updated at the edge and compared against the DUT.
    task automatic step(input logic r, input logic p, input logic o, input logic f,
                        input logic [29:0] pc, input logic [31:0] ins);
        int   n;
        logic byp, pop_ok, push_ok;
        ent_t exp;
        @(negedge CLK);
        reset = r; push = p; pop = o; flush = f; pc_in = pc; instr_in = ins;
        #1;
        n = model.size();
`ifdef FETCH_QUEUE_BYPASS_EN
        byp = (n == 0) && p && !f;
`else
        byp = 1'b0;
`endif
        check("valid_out_pre", valid_out, (n != 0) || byp);
        check("full_pre", full, n == DEPTH);
        if (o && (n != 0 || byp)) begin
            exp = byp ? ent_t'{pc, ins} : model[0];
            check("head_pc", pc_out, exp.pc);
            check("head_instr", instr_out, exp.instr);
        end
        @(posedge CLK);
        if (r || f) begin
            model.delete();
        end else begin
            pop_ok  = o && (n != 0);
            push_ok = p && (n < DEPTH || pop_ok);
            if (byp) begin
                if (!o) model.push_back(ent_t'{pc, ins});
            end else begin
                if (pop_ok) void'(model.pop_front());
                if (push_ok) model.push_back(ent_t'{pc, ins});
            end
        end
        #1;
        check("count_model", count, model.size());
        check("count_bound", count <= DEPTH, 1'b1);
    endtask

    initial begin
        reset = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
        pc_in = '0; instr_in = '0;
        repeat (2) @(posedge CLK);
        #1;
        check("rst_count", count, 3'd0);
        check("rst_valid", valid_out, 1'b0);
        check("rst_full", full, 1'b0);
        check("rst_pc", pc_out, 30'h0000_0C00);
        check("rst_instr", instr_out, 32'h0);

        //            rst  push pop  flush pc         cnt  v     full  head pc
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC00, 3'd1, 1'b1, 1'b0, 30'hC00};
        vecs[1]  = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC01, 3'd2, 1'b1, 1'b0, 30'hC00};
        vecs[2]  = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC02, 3'd3, 1'b1, 1'b0, 30'hC00};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC03, 3'd4, 1'b1, 1'b1, 30'hC00};
        vecs[4]  = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC04, 3'd4, 1'b1, 1'b1, 30'hC00};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b0, 30'hC04, 3'd4, 1'b1, 1'b1, 30'hC01};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 30'h000, 3'd3, 1'b1, 1'b0, 30'hC02};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 30'h000, 3'd2, 1'b1, 1'b0, 30'hC03};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 30'h000, 3'd1, 1'b1, 1'b0, 30'hC04};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 30'h000, 3'd0, 1'b0, 1'b0, 30'hC00};
        vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 30'h000, 3'd0, 1'b0, 1'b0, 30'hC00};
        vecs[11] = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC05, 3'd1, 1'b1, 1'b0, 30'hC05};
        vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC06, 3'd2, 1'b1, 1'b0, 30'hC05};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC07, 3'd3, 1'b1, 1'b0, 30'hC05};
        vecs[14] = '{1'b0, 1'b1, 1'b0, 1'b1, 30'hC08, 3'd0, 1'b0, 1'b0, 30'hC00};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC09, 3'd1, 1'b1, 1'b0, 30'hC09};
        vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 30'hC0A, 3'd2, 1'b1, 1'b0, 30'hC09};
        vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b0, 30'hC0B, 3'd0, 1'b0, 1'b0, 30'hC00};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 30'h000, 3'd0, 1'b0, 1'b0, 30'hC00};

        for (int i = 0; i < 19; i++) begin
            step(vecs[i].rst, vecs[i].p, vecs[i].o, vecs[i].f, vecs[i].pc, mk(vecs[i].pc));
            check($sformatf("vec%0d_count", i), count, vecs[i].cnt);
            check($sformatf("vec%0d_valid", i), valid_out, vecs[i].v);
            check($sformatf("vec%0d_full", i), full, vecs[i].fl);
            check($sformatf("vec%0d_pc", i), pc_out, vecs[i].hpc);
            check($sformatf("vec%0d_instr", i), instr_out, vecs[i].v ? mk(vecs[i].hpc) : 32'h0);
        end

        // Pointer wrap: hold two entries while ten push/pop pairs rotate through the array.
        step(1'b0, 1'b1, 1'b0, 1'b0, 30'hC20, mk(30'hC20));
        step(1'b0, 1'b1, 1'b0, 1'b0, 30'hC21, mk(30'hC21));
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 1'b1, 1'b0, 30'hC22 + 30'(i), mk(30'hC22 + 30'(i)));
            check("wrap_count", count, 3'd2);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 32'h0);
        step(1'b0, 1'b0, 1'b1, 1'b0, 30'h0, 32'h0);
        check("wrap_drained", valid_out, 1'b0);

        // Push and pop together on an empty queue.
        step(1'b0, 1'b1, 1'b1, 1'b0, 30'hC10, mk(30'hC10));
`ifdef FETCH_QUEUE_BYPASS_EN
        check("bypass_count", count, 3'd0);
`else
        check("nobypass_count", count, 3'd1);
        check("nobypass_head", pc_out, 30'hC10);
`endif
        step(1'b0, 1'b0, 1'b0, 1'b1, 30'h0, 32'h0);

        // Random traffic against the scoreboard.
        for (int i = 0; i < 200; i++) begin
            logic [29:0] rpc;
            rpc = 30'($urandom);
            step(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 ($urandom_range(0, 15) == 0), rpc, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
